// File: rtl/test_always_decoder.sv
// Receive-side decoder for the counter/phase-keyed symbol encoder: regenerates the key locally and recovers sym.
// 1-cycle latency enc_in -> data_out; 1-deep output register, enc_ready = !data_valid || data_ready while locked.
module test_always_decoder #(
  parameter int WIDTH    = 8,
  parameter int CNT_STEP = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [WIDTH-1:0]  enc_in,
  input  logic              enc_valid,
  output logic              enc_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              locked,
  output logic              drop_err,
  output logic [STAT_W-1:0] sym_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]  STEP     = WIDTH'(CNT_STEP);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t            state;
  logic [WIDTH-1:0]  cnt;
  logic              phase;

  logic              accept;
  logic [WIDTH-1:0]  cnt_eff;
  logic              phase_eff;
  logic [STAT_W-1:0] count_base;

  assign enc_ready = (state == RUN) && (!data_valid || data_ready);
  assign accept    = enc_valid && enc_ready;

  // A sync coinciding with an accept keys that very symbol from cnt=0/phase=0.
  assign cnt_eff    = sync ? '0 : cnt;
  assign phase_eff  = sync ? 1'b0 : phase;
  assign count_base = sync ? '0 : sym_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      drop_err   <= 1'b0;
      sym_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync) begin
            state     <= RUN;
            locked    <= 1'b1;
            cnt       <= '0;
            phase     <= 1'b0;
            sym_count <= '0;
          end else if (enc_valid) begin
            drop_err <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            data_out   <= phase_eff ? enc_in - cnt_eff : enc_in + cnt_eff;
            data_valid <= 1'b1;
            cnt        <= cnt_eff + STEP;
            phase      <= ~phase_eff;
            sym_count  <= (count_base == STAT_MAX) ? count_base : count_base + 1'b1;
          end else begin
            if (data_ready) data_valid <= 1'b0;
            // Resync without a symbol: key restarts, the held output word is untouched.
            if (sync) begin
              cnt       <= '0;
              phase     <= 1'b0;
              sym_count <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_always_decoder.sv
// Bench for test_always_decoder: driver pushes expected words on accept, a monitor pops them on output transfers.
module tb_test_always_decoder;

  logic        clk;
  logic        reset;
  logic        sync;
  logic [7:0]  enc_in;
  logic        enc_valid;
  logic        enc_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        locked;
  logic        drop_err;
  logic [15:0] sym_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  test_always_decoder #(.WIDTH(8), .CNT_STEP(1), .STAT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .enc_in     (enc_in),
    .enc_valid  (enc_valid),
    .enc_ready  (enc_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .locked     (locked),
    .drop_err   (drop_err),
    .sym_count  (sym_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no word at %0t", data_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL data_out: got 0x%0h, expected 0x%0h at %0t", data_out, e, $time);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] e, input logic [7:0] exp, input logic s, output int waited);
    enc_valid = 1'b1;
    enc_in    = e;
    sync      = s;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (enc_ready) begin
        exp_q.push_back(exp);
        break;
      end
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got enc_ready=0, expected 1 within 50 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    enc_valid = 1'b0;
    sync      = 1'b0;
    if (waited <= 50) chk("latency_data_valid", data_valid, 1);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] sym, key, enc;
    reset = 1'b1; sync = 1'b0; enc_in = '0; enc_valid = 1'b0; data_ready = 1'b1;
    idle(2);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_enc_ready", enc_ready, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // T4: traffic before sync is dropped and flagged
    enc_valid = 1'b1; enc_in = 8'h99;
    @(negedge clk);
    chk("t4_enc_ready", enc_ready, 0);
    @(posedge clk); #1;
    enc_valid = 1'b0;
    chk("t4_drop_err", drop_err, 1);
    chk("t4_no_valid", data_valid, 0);
    idle(3);
    chk("t4_drop_sticky", drop_err, 1);
    chk("t4_locked", locked, 0);

    // T1: basic decode
    do_sync();
    chk("t1_locked", locked, 1);
    chk("t1_count0", sym_count, 0);
    send(8'h10, 8'h10, 1'b0, w);
    send(8'h21, 8'h20, 1'b0, w);
    send(8'h03, 8'h05, 1'b0, w);
    idle(2);
    chk("t1_sym_count", sym_count, 3);
    chk("t1_drained", data_valid, 0);

    // T2: key wrap; symbols are encoded here so each decodes to a known value
    do_sync();
    for (int i = 0; i < 255; i++) begin
      sym = 8'(i) ^ 8'h5A;
      key = 8'(i);
      enc = i[0] ? sym + key : sym - key;
      send(enc, sym, 1'b0, w);
    end
    send(8'h00, 8'h01, 1'b0, w);
    send(8'h37, 8'h37, 1'b0, w);
    idle(2);
    chk("t2_sym_count", sym_count, 257);

    // T3: backpressure holds the word, release accepts with no bubble
    do_sync();
    send(8'h11, 8'h11, 1'b0, w);
    data_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_valid", data_valid, 1);
      chk("t3_hold_data", data_out, 8'h11);
      chk("t3_enc_ready", enc_ready, 0);
      @(posedge clk); #1;
    end
    data_ready = 1'b1;
    send(8'h25, 8'h24, 1'b0, w);
    chk("t3_no_bubble_wait", w, 0);
    chk("t3_new_word", data_out, 8'h24);

    // T5: resync together with an accept
    send(8'h42, 8'h42, 1'b1, w);
    send(8'h44, 8'h43, 1'b0, w);
    chk("t5_sym_count", sym_count, 2);
    idle(2);

    // T6: async reset while a word is held
    data_ready = 1'b0;
    send(8'h55, 8'h57, 1'b0, w);
    chk("t6_held", data_valid, 1);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_data_valid", data_valid, 0);
    chk("t6_data_out", data_out, 0);
    chk("t6_locked", locked, 0);
    chk("t6_sym_count", sym_count, 0);
    chk("t6_drop_err", drop_err, 0);
    @(negedge clk); reset = 1'b0;
    data_ready = 1'b1;
    @(posedge clk); #1;
    idle(2);
    chk("t6_locked_after", locked, 0);
    chk("t6_enc_ready_after", enc_ready, 0);
    do_sync();
    chk("t6_relock", locked, 1);
    send(8'h12, 8'h12, 1'b0, w);
    idle(3);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
